// File: rtl/fb_arbiter_if.sv
// Bus bundle for the framebuffer arbiter: VGA prefetch port, CPU port and the
// shared framebuffer memory port. The arbiter uses the slave view; the
// surrounding system (requesters and memory) uses the master view.
interface fb_arbiter_if;
  // VGA prefetch read port
  logic        vga_access;
  logic [15:0] vga_address;
  logic        vga_ack;
  logic [15:0] vga_data;
  // CPU read/write port
  logic        cpu_access;
  logic [15:0] cpu_address;
  logic        cpu_wr_en;
  logic [1:0]  cpu_bytesel;
  logic [15:0] cpu_wr_data;
  logic        cpu_ack;
  logic [15:0] cpu_data;
  // Framebuffer memory port
  logic        mem_access;
  logic [15:0] mem_address;
  logic        mem_wr_en;
  logic [1:0]  mem_bytesel;
  logic [15:0] mem_wr_data;
  logic        mem_ack;
  logic [15:0] mem_data;

  modport master (
    output vga_access, vga_address,
    input  vga_ack, vga_data,
    output cpu_access, cpu_address, cpu_wr_en, cpu_bytesel, cpu_wr_data,
    input  cpu_ack, cpu_data,
    input  mem_access, mem_address, mem_wr_en, mem_bytesel, mem_wr_data,
    output mem_ack, mem_data
  );

  modport slave (
    input  vga_access, vga_address,
    output vga_ack, vga_data,
    input  cpu_access, cpu_address, cpu_wr_en, cpu_bytesel, cpu_wr_data,
    output cpu_ack, cpu_data,
    output mem_access, mem_address, mem_wr_en, mem_bytesel, mem_wr_data,
    input  mem_ack, mem_data
  );
endinterface

// File: rtl/fb_arbiter.sv
// Framebuffer arbiter: shares one memory port between the VGA prefetch
// engine and the CPU. VGA normally wins, but after MAX_VGA_BURST consecutive
// VGA grants made while the CPU was waiting, the CPU gets the next slot.
// One transfer at a time; the memory port drops for at least one cycle
// between transfers.
module fb_arbiter #(
  parameter int MAX_VGA_BURST = 8
) (
  input  logic        sys_clk,
  input  logic        reset,
  fb_arbiter_if.slave bus
);

  localparam int              STREAK_W    = $clog2(MAX_VGA_BURST + 1);
  localparam logic [STREAK_W-1:0] BURST_LIMIT = STREAK_W'(MAX_VGA_BURST);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_VGA_XFER = 2'd1;
  localparam logic [1:0] ST_CPU_XFER = 2'd2;

  logic [1:0]          r_state;
  logic [STREAK_W-1:0] r_streak;
  logic                r_mem_access;
  logic [15:0]         r_mem_address;
  logic                r_mem_wr_en;
  logic [1:0]          r_mem_bytesel;
  logic [15:0]         r_mem_wr_data;

  logic                w_streak_full;
  logic                w_grant_vga;
  logic                w_grant_cpu;
  logic [STREAK_W-1:0] w_streak_next_vga;
  logic                w_vga_ack;
  logic                w_cpu_ack;

  // Grant decision for an IDLE cycle and the streak value a VGA grant leaves behind
  always_comb begin
    w_streak_full = (r_streak == BURST_LIMIT);
    w_grant_vga   = bus.vga_access & ~(bus.cpu_access & w_streak_full);
    w_grant_cpu   = bus.cpu_access & ~w_grant_vga;
    if (!bus.cpu_access) begin
      w_streak_next_vga = '0;
    end else if (w_streak_full) begin
      w_streak_next_vga = BURST_LIMIT;
    end else begin
      w_streak_next_vga = r_streak + STREAK_W'(1);
    end
  end

  // Completion pulses follow the memory ack of the owning transfer; suppressed in reset
  always_comb begin
    w_vga_ack = bus.mem_ack & (r_state == ST_VGA_XFER) & ~reset;
    w_cpu_ack = bus.mem_ack & (r_state == ST_CPU_XFER) & ~reset;
  end

  // Arbitration FSM: latch the winner's request on a grant, hold it until mem_ack
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_streak      <= '0;
      r_mem_access  <= 1'b0;
      r_mem_address <= 16'h0000;
      r_mem_wr_en   <= 1'b0;
      r_mem_bytesel <= 2'b00;
      r_mem_wr_data <= 16'h0000;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_grant_vga) begin
            r_state       <= ST_VGA_XFER;
            r_streak      <= w_streak_next_vga;
            r_mem_access  <= 1'b1;
            r_mem_address <= bus.vga_address;
            r_mem_wr_en   <= 1'b0;
            r_mem_bytesel <= 2'b11;
            r_mem_wr_data <= 16'h0000;
          end else if (w_grant_cpu) begin
            r_state       <= ST_CPU_XFER;
            r_streak      <= '0;
            r_mem_access  <= 1'b1;
            r_mem_address <= bus.cpu_address;
            r_mem_wr_en   <= bus.cpu_wr_en;
            r_mem_bytesel <= bus.cpu_bytesel;
            r_mem_wr_data <= bus.cpu_wr_data;
          end else begin
            r_state      <= ST_IDLE;
            r_mem_access <= 1'b0;
          end
        end
        ST_VGA_XFER, ST_CPU_XFER: begin
          // Requester inputs are ignored here so an in-flight transfer is never disturbed
          if (bus.mem_ack) begin
            r_state      <= ST_IDLE;
            r_mem_access <= 1'b0;
          end else begin
            r_state      <= r_state;
            r_mem_access <= 1'b1;
          end
        end
        default: begin
          r_state      <= ST_IDLE;
          r_mem_access <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_access  = r_mem_access;
  assign bus.mem_address = r_mem_address;
  assign bus.mem_wr_en   = r_mem_wr_en;
  assign bus.mem_bytesel = r_mem_bytesel;
  assign bus.mem_wr_data = r_mem_wr_data;
  assign bus.vga_ack     = w_vga_ack;
  assign bus.cpu_ack     = w_cpu_ack;
  assign bus.vga_data    = bus.mem_data;
  assign bus.cpu_data    = bus.mem_data;

endmodule

// File: tb/tb_fb_arbiter.sv
// Self-checking bench for fb_arbiter: directed scenarios plus randomized
// traffic, all checked cycle by cycle against a transaction-level reference.
module tb_fb_arbiter;

  localparam int MAXB = 8;

  logic sys_clk = 1'b0;
  logic reset   = 1'b1;

  fb_arbiter_if bus();

  fb_arbiter #(.MAX_VGA_BURST(MAXB)) dut (
    .sys_clk(sys_clk),
    .reset  (reset),
    .bus    (bus)
  );

  always #5 sys_clk = ~sys_clk;

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- stimulus configuration (written by main only) ----------------
  int          vga_mode = 0;   // 0 none, 1 random, 2 continuous, 3 one-shot on token
  int          cpu_mode = 0;
  int          vga_tok  = 0;
  int          cpu_tok  = 0;
  bit          vga_fix  = 1'b0;
  bit          cpu_fix  = 1'b0;
  logic [15:0] vga_fix_addr = 16'h0000;
  logic [15:0] cpu_fix_addr = 16'h0000;
  logic        cpu_fix_we   = 1'b0;
  logic [1:0]  cpu_fix_bs   = 2'b00;
  logic [15:0] cpu_fix_wd   = 16'h0000;
  int          lat_cfg  = 0;   // <0 random latency 0..3
  bit          spur_en  = 1'b0;
  bit          viol_en  = 1'b0;
  bit          data_fix = 1'b0;
  logic [15:0] data_fix_val = 16'h0000;

  // ---------------- reference model state (written by checker only) ----------------
  int          m_owner  = 0;   // 0 nobody, 1 VGA, 2 CPU
  int          m_streak = 0;
  logic [15:0] m_addr   = 16'h0000;
  logic        m_we     = 1'b0;
  logic [1:0]  m_bs     = 2'b00;
  logic [15:0] m_wd     = 16'h0000;
  bit          ev_vga_ack = 1'b0;
  bit          ev_cpu_ack = 1'b0;
  int          n_vack = 0;
  int          n_cack = 0;
  logic [15:0] last_vga_data = 16'h0000;
  logic        prev_acc = 1'b0;
  logic [15:0] g_addr[$];
  logic        g_we[$];
  logic [1:0]  g_bs[$];
  logic [15:0] g_wd[$];

  int vga_done_tok = 0;
  int cpu_done_tok = 0;
  int resp_cnt     = 0;

  function automatic bit want_start(input int mode, input int tok, input int done);
    case (mode)
      1:       return ($urandom_range(0, 3) == 0);
      2:       return 1'b1;
      3:       return (tok != done);
      default: return 1'b0;
    endcase
  endfunction

  // Requesters: hold access until the expected ack, then optionally reissue
  initial begin
    bus.vga_access = 1'b0; bus.vga_address = 16'h0000;
    bus.cpu_access = 1'b0; bus.cpu_address = 16'h0000;
    bus.cpu_wr_en  = 1'b0; bus.cpu_bytesel = 2'b00; bus.cpu_wr_data = 16'h0000;
    forever begin
      @(posedge sys_clk); #1;
      if (bus.vga_access) begin
        if (ev_vga_ack) bus.vga_access = 1'b0;
        else if (viol_en && m_owner == 1 && $urandom_range(0, 39) == 0) bus.vga_access = 1'b0;
      end
      if (!bus.vga_access && m_owner != 1 && want_start(vga_mode, vga_tok, vga_done_tok)) begin
        if (vga_mode == 3) vga_done_tok = vga_tok;
        bus.vga_access  = 1'b1;
        bus.vga_address = vga_fix ? vga_fix_addr : 16'($urandom);
      end
      if (bus.cpu_access) begin
        if (ev_cpu_ack) bus.cpu_access = 1'b0;
        else if (viol_en && m_owner == 2 && $urandom_range(0, 39) == 0) bus.cpu_access = 1'b0;
      end
      if (!bus.cpu_access && m_owner != 2 && want_start(cpu_mode, cpu_tok, cpu_done_tok)) begin
        if (cpu_mode == 3) cpu_done_tok = cpu_tok;
        bus.cpu_access  = 1'b1;
        bus.cpu_address = cpu_fix ? cpu_fix_addr : 16'($urandom);
        bus.cpu_wr_en   = cpu_fix ? cpu_fix_we   : 1'($urandom);
        bus.cpu_bytesel = cpu_fix ? cpu_fix_bs   : 2'($urandom);
        bus.cpu_wr_data = cpu_fix ? cpu_fix_wd   : 16'($urandom);
      end
    end
  end

  // Memory responder: one-cycle ack after a configurable latency, optional spurious acks
  initial begin
    bus.mem_ack = 1'b0; bus.mem_data = 16'h0000;
    forever begin
      @(posedge sys_clk); #1;
      if (bus.mem_ack) begin
        bus.mem_ack = 1'b0;
      end else if (m_owner != 0) begin
        if (resp_cnt <= 0) begin
          bus.mem_ack  = 1'b1;
          bus.mem_data = data_fix ? data_fix_val : 16'($urandom);
        end else begin
          resp_cnt--;
        end
      end else begin
        resp_cnt = (lat_cfg < 0) ? int'($urandom_range(0, 3)) : lat_cfg;
        if (spur_en && $urandom_range(0, 5) == 0) begin
          bus.mem_ack  = 1'b1;
          bus.mem_data = 16'($urandom);
        end
      end
    end
  end

  // Checker: compare DUT against the reference, then advance the reference one cycle
  initial begin
    bit exp_v, exp_c;
    forever begin
      @(negedge sys_clk);
      exp_v = bus.mem_ack && m_owner == 1 && !reset;
      exp_c = bus.mem_ack && m_owner == 2 && !reset;
      check_eq("vga_ack",     bus.vga_ack,     exp_v);
      check_eq("cpu_ack",     bus.cpu_ack,     exp_c);
      check_eq("mem_access",  bus.mem_access,  (m_owner != 0));
      check_eq("mem_address", bus.mem_address, m_addr);
      check_eq("mem_wr_en",   bus.mem_wr_en,   m_we);
      check_eq("mem_bytesel", bus.mem_bytesel, m_bs);
      check_eq("mem_wr_data", bus.mem_wr_data, m_wd);
      if (exp_v) check_eq("vga_data", bus.vga_data, bus.mem_data);
      if (exp_c) check_eq("cpu_data", bus.cpu_data, bus.mem_data);
      ev_vga_ack = exp_v;
      ev_cpu_ack = exp_c;
      if (bus.vga_ack === 1'b1) begin n_vack++; last_vga_data = bus.vga_data; end
      if (bus.cpu_ack === 1'b1) n_cack++;
      if (bus.mem_access === 1'b1 && prev_acc !== 1'b1) begin
        g_addr.push_back(bus.mem_address); g_we.push_back(bus.mem_wr_en);
        g_bs.push_back(bus.mem_bytesel);   g_wd.push_back(bus.mem_wr_data);
      end
      prev_acc = bus.mem_access;
      if (reset) begin
        m_owner = 0; m_streak = 0; m_addr = 16'h0000; m_we = 1'b0; m_bs = 2'b00; m_wd = 16'h0000;
      end else if (m_owner == 0) begin
        if (bus.vga_access && !(bus.cpu_access && m_streak == MAXB)) begin
          m_owner = 1; m_addr = bus.vga_address; m_we = 1'b0; m_bs = 2'b11; m_wd = 16'h0000;
          m_streak = bus.cpu_access ? ((m_streak + 1 > MAXB) ? MAXB : m_streak + 1) : 0;
        end else if (bus.cpu_access) begin
          m_owner = 2; m_addr = bus.cpu_address; m_we = bus.cpu_wr_en;
          m_bs = bus.cpu_bytesel; m_wd = bus.cpu_wr_data; m_streak = 0;
        end
      end else if (bus.mem_ack) begin
        m_owner = 0;
      end
    end
  end

  // ---------------- main sequence helpers ----------------
  task automatic cyc(input int n);
    repeat (n) @(posedge sys_clk);
    #2;
  endtask

  task automatic wait_acks(input int wv, input int wc, input int budget, input string tag);
    int g;
    g = 0;
    while ((n_vack < wv || n_cack < wc) && g < budget) begin
      cyc(1);
      g++;
    end
    check_eq(tag, n_vack + n_cack, wv + wc);
  endtask

  task automatic do_reset();
    cyc(1);
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
  endtask

  // Main scenario sequence
  initial begin
    int bv, bc, gb, g;
    bit seen;
    cyc(3);
    @(negedge sys_clk);
    check_eq("rst_mem_access",  bus.mem_access,  1'b0);
    check_eq("rst_mem_address", bus.mem_address, 16'h0000);
    check_eq("rst_mem_wr_en",   bus.mem_wr_en,   1'b0);
    check_eq("rst_mem_bytesel", bus.mem_bytesel, 2'b00);
    check_eq("rst_mem_wr_data", bus.mem_wr_data, 16'h0000);
    cyc(1);
    reset = 1'b0;

    // VGA-only read, memory answers 3 cycles after mem_access
    lat_cfg = 3; data_fix = 1'b1; data_fix_val = 16'hBEEF;
    vga_fix = 1'b1; vga_fix_addr = 16'h0123; vga_mode = 3; vga_tok++;
    bv = n_vack; gb = g_addr.size();
    wait_acks(bv + 1, n_cack, 40, "vga_only_done");
    check_eq("vga_only_data", last_vga_data, 16'hBEEF);
    check_eq("vga_only_grants", g_addr.size(), gb + 1);
    if (g_addr.size() == gb + 1) begin
      check_eq("vga_only_addr", g_addr[gb], 16'h0123);
      check_eq("vga_only_bs",   g_bs[gb],   2'b11);
    end
    @(negedge sys_clk);
    check_eq("vga_only_gap", bus.mem_access, 1'b0);

    // CPU byte write
    vga_mode = 0; data_fix = 1'b0; lat_cfg = 1;
    cpu_fix = 1'b1; cpu_fix_addr = 16'h1000; cpu_fix_we = 1'b1; cpu_fix_bs = 2'b01; cpu_fix_wd = 16'h00AA;
    cyc(1);
    bv = n_vack; bc = n_cack; gb = g_addr.size();
    cpu_mode = 3; cpu_tok++;
    wait_acks(bv, bc + 1, 40, "cpu_wr_done");
    check_eq("cpu_wr_no_vga_ack", n_vack, bv);
    check_eq("cpu_wr_grants", g_addr.size(), gb + 1);
    if (g_addr.size() == gb + 1) begin
      check_eq("cpu_wr_addr", g_addr[gb], 16'h1000);
      check_eq("cpu_wr_we",   g_we[gb],   1'b1);
      check_eq("cpu_wr_bs",   g_bs[gb],   2'b01);
      check_eq("cpu_wr_wd",   g_wd[gb],   16'h00AA);
    end

    // Simultaneous one-shot requests with a fresh streak: VGA first, then CPU
    cpu_mode = 0;
    do_reset();
    vga_fix_addr = 16'h0A00; cpu_fix_addr = 16'hC000; cpu_fix_we = 1'b0;
    bv = n_vack; bc = n_cack; gb = g_addr.size();
    vga_mode = 3; cpu_mode = 3; vga_tok++; cpu_tok++;
    wait_acks(bv + 1, bc + 1, 40, "simul_done");
    check_eq("simul_grants", g_addr.size(), gb + 2);
    if (g_addr.size() >= gb + 2) begin
      check_eq("simul_first",  g_addr[gb],     16'h0A00);
      check_eq("simul_second", g_addr[gb + 1], 16'hC000);
    end

    // Starvation limit: both requesting back to back
    vga_mode = 0; cpu_mode = 0;
    do_reset();
    lat_cfg = 0; gb = g_addr.size();
    vga_mode = 2; cpu_mode = 2;
    g = 0;
    while (g_addr.size() < gb + 27 && g < 800) begin cyc(1); g++; end
    vga_mode = 0; cpu_mode = 0;
    cyc(20);
    check_eq("starve_len_ok", (g_addr.size() >= gb + 27), 1'b1);
    if (g_addr.size() >= gb + 27) begin
      for (int k = 0; k < 27; k++)
        check_eq($sformatf("starve_%0d", k), g_addr[gb + k], (k % 9 == 8) ? 16'hC000 : 16'h0A00);
    end

    // Reset while a CPU transfer is being acked: ack suppressed, transfer dropped
    lat_cfg = 2; bc = n_cack;
    cpu_mode = 3; cpu_tok++;
    seen = 1'b0; g = 0;
    while (!seen && g < 40) begin
      cyc(1); g++;
      seen = (bus.mem_ack === 1'b1) && (m_owner == 2);
    end
    check_eq("rst_xfer_seen", seen, 1'b1);
    reset = 1'b1;
    @(negedge sys_clk);
    check_eq("rst_no_cpu_ack", bus.cpu_ack, 1'b0);
    cyc(1);
    reset = 1'b0;
    @(negedge sys_clk);
    check_eq("rst_abandon", bus.mem_access, 1'b0);
    check_eq("rst_ack_count", n_cack, bc);
    wait_acks(n_vack, bc + 1, 40, "cpu_reissue");

    // Spurious memory acks while idle
    cpu_mode = 0; cyc(5);
    bv = n_vack; bc = n_cack;
    spur_en = 1'b1;
    cyc(30);
    spur_en = 1'b0;
    @(negedge sys_clk);
    check_eq("spur_idle", bus.mem_access, 1'b0);
    check_eq("spur_acks", n_vack + n_cack, bv + bc);

    // Randomized traffic with protocol violations and occasional resets
    vga_fix = 1'b0; cpu_fix = 1'b0; lat_cfg = -1; spur_en = 1'b1; viol_en = 1'b1;
    bv = n_vack; bc = n_cack;
    vga_mode = 1; cpu_mode = 1;
    for (int i = 0; i < 3000; i++) begin
      cyc(1);
      reset = ($urandom_range(0, 299) == 0);
    end
    reset = 1'b0; vga_mode = 0; cpu_mode = 0; spur_en = 1'b0; viol_en = 1'b0;
    cyc(30);
    check_eq("rand_progress", (n_vack > bv + 50) && (n_cack > bc + 50), 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fb_arbiter.md
FB_ARBITER -- requirements
Module: fb_arbiter

Interface
REQ-001 Parameter: MAX_VGA_BURST, default 8, meaning max consecutive VGA grants while CPU is pending (legal 1..255).
REQ-002 sys_clk  in  1  sole clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 vga_access  in  1  prefetch word-read request; held until vga_ack.
REQ-005 vga_address  in  16  prefetch word address.
REQ-006 vga_ack  out  1  one-cycle completion pulse to prefetch.
REQ-007 vga_data  out  16  read data, valid while vga_ack=1.
REQ-008 cpu_access  in  1  CPU request; held until cpu_ack.
REQ-009 cpu_address  in  16  CPU word address.
REQ-010 cpu_wr_en  in  1  1=write, 0=read.
REQ-011 cpu_bytesel  in  2  byte enables, [0]=low byte.
REQ-012 cpu_wr_data  in  16  write data.
REQ-013 cpu_ack  out  1  one-cycle completion pulse to CPU.
REQ-014 cpu_data  out  16  read data, valid while cpu_ack=1.
REQ-015 mem_access  out  1  framebuffer memory request.
REQ-016 mem_address  out  16  memory word address.
REQ-017 mem_wr_en  out  1  memory write strobe qualifier.
REQ-018 mem_bytesel  out  2  memory byte enables.
REQ-019 mem_wr_data  out  16  memory write data.
REQ-020 mem_ack  in  1  memory completion pulse; mem_data valid same cycle.
REQ-021 mem_data  in  16  memory read data.

Function
REQ-022 FSM states SHALL be IDLE, VGA_XFER, CPU_XFER; mem_access = (state != IDLE), registered.
REQ-023 In IDLE with no request, state SHALL remain IDLE.
REQ-024 In IDLE, VGA SHALL win over CPU when both request, unless streak == MAX_VGA_BURST, in which case CPU SHALL win.
REQ-025 On a grant decision, mem_address/mem_wr_en/mem_bytesel/mem_wr_data SHALL be registered from the winner and held constant until the transfer ends.
REQ-026 VGA grants SHALL drive mem_wr_en=0, mem_bytesel=2'b11, mem_wr_data=0.
REQ-027 Latency: request seen in IDLE at cycle N -> mem_access=1 at cycle N+1.
REQ-028 In VGA_XFER/CPU_XFER, state SHALL hold until mem_ack=1, then return to IDLE next cycle (mem_access low for at least one cycle between transfers).
REQ-029 vga_ack SHALL equal mem_ack & (state==VGA_XFER); cpu_ack SHALL equal mem_ack & (state==CPU_XFER); combinational.
REQ-030 vga_data and cpu_data SHALL pass mem_data through combinationally; value outside an ack cycle is don't-care.
REQ-031 mem_ack while IDLE SHALL be ignored: no ack generated, no state change.
REQ-032 Streak counter width clog2(MAX_VGA_BURST+1): increment (saturating at MAX_VGA_BURST) on each VGA grant made with cpu_access=1; clear on each CPU grant; clear on any VGA grant made with cpu_access=0.
REQ-033 Requester deasserting access before ack (protocol violation) SHALL NOT abort an in-flight transfer; the ack is still issued.
REQ-034 Input changes during an in-flight transfer SHALL NOT alter mem_* outputs.

Reset
REQ-035 reset=1 at a rising edge SHALL force state=IDLE, streak=0, mem_access=0, mem_wr_en=0, mem_bytesel=0, mem_address=0, mem_wr_data=0.
REQ-036 vga_ack and cpu_ack SHALL be 0 while reset=1, even if mem_ack=1.
REQ-037 Reset mid-transfer SHALL abandon the transfer with no ack; requesters reissue after reset.

Verification
REQ-038 VGA only: vga_access=1, vga_address=16'h0123, mem_ack 3 cycles after mem_access, mem_data=16'hBEEF -> mem_access at N+1, vga_ack one cycle with vga_data=16'hBEEF, mem_access low the following cycle.
REQ-039 CPU write: cpu_access=1, cpu_wr_en=1, cpu_bytesel=2'b01, address 16'h1000, data 16'h00AA -> mem_wr_en=1, mem_bytesel=2'b01, mem_address=16'h1000, mem_wr_data=16'h00AA; cpu_ack on mem_ack; vga_ack stays 0.
REQ-040 Starvation: MAX_VGA_BURST=8, both requesting continuously -> exactly 8 VGA grants, then 1 CPU grant, then VGA resumes; pattern repeats.
REQ-041 Simultaneous request with streak=0 -> VGA granted first, CPU granted on the next IDLE decision if VGA not re-requesting.
REQ-042 Reset asserted during CPU_XFER with mem_ack=1 in the same cycle -> no cpu_ack, mem_access=0 next cycle, streak=0.
REQ-043 Spurious mem_ack in IDLE -> no ack outputs, state remains IDLE.
